// File: rtl/rob_dispatch.sv
// Dispatch stage between the command stream and the ROB write port: a single-entry
// hold register, credit-based round-robin assignment of iNTT units, and credit return.
//
//   state   | meaning
//   S_EMPTY | no command held; cmd_ready=1
//   S_HELD  | command held; written to the ROB when it has room and some unit has credit
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef LWE_BIT_WIDTH
`define LWE_BIT_WIDTH 16
`endif
`ifndef INTT_ID_WIDTH
`define INTT_ID_WIDTH 2
`endif
`ifndef INVALIDOP
`define INVALIDOP 4'd0
`endif
`ifndef BOOTSTRAP
`define BOOTSTRAP 4'd1
`endif
`ifndef RLWESUBS
`define RLWESUBS 4'd2
`endif
`ifndef OR
`define OR   3'd0
`define AND  3'd1
`define NOR  3'd2
`define NAND 3'd3
`define XOR  3'd4
`define XNOR 3'd5
`endif

module rob_dispatch #(
   parameter int NUM_INTT     = 2,
   parameter int INTT_CREDITS = 2,
   parameter int CREDIT_WIDTH = $clog2(INTT_CREDITS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [`OPCODE_WIDTH-1:0]      cmd_opcode,
   input  logic [2:0]                    cmd_gate,
   input  logic [`LWE_BIT_WIDTH-1:0]     cmd_init_value,
   input  logic [3:0]                    cmd_subs_factor,
   input  logic                          ROB_full,
   input  logic                          ROB_empty,
   output logic                          wr_en,
   output logic [2:0]                    gate_out,
   output logic [`OPCODE_WIDTH-1:0]      opcode_out,
   output logic [`INTT_ID_WIDTH-1:0]     iNTT_id_out,
   output logic [`LWE_BIT_WIDTH-1:0]     init_value_out,
   output logic [3:0]                    subs_factor_out,
   input  logic [NUM_INTT-1:0]           iNTT_done,
   output logic                          busy,
   output logic                          credit_err
);

   localparam int ID_W = `INTT_ID_WIDTH;
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(INTT_CREDITS);

   typedef enum logic {S_EMPTY, S_HELD} state_t;

   state_t                       state_q, state_d;
   logic [2:0]                   hold_gate_q, hold_gate_d;
   logic [`OPCODE_WIDTH-1:0]     hold_opcode_q, hold_opcode_d;
   logic [`LWE_BIT_WIDTH-1:0]    hold_init_q, hold_init_d;
   logic [3:0]                   hold_subs_q, hold_subs_d;
   logic [CREDIT_WIDTH-1:0]      credit_q [NUM_INTT];
   logic [CREDIT_WIDTH-1:0]      credit_d [NUM_INTT];
   logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic                         credit_err_q, credit_err_d;

   logic [NUM_INTT-1:0]          credit_nz;
   logic                         any_credit;
   logic                         found;
   logic [ID_W-1:0]              grant;
   int                           ptr_int;
   logic                         hold_valid;
   logic                         accept;
   logic                         accept_valid;

   assign hold_valid = (state_q == S_HELD);

   // Round-robin scan starting at rr_ptr; first unit with nonzero credit wins.
   always_comb begin
      credit_nz = '0;
      for (int i = 0; i < NUM_INTT; i++) begin
         credit_nz[i] = (credit_q[i] != '0);
      end
      any_credit = |credit_nz;
      ptr_int    = int'(rr_ptr_q);
      found      = 1'b0;
      grant      = '0;
      for (int k = 0; k < NUM_INTT; k++) begin
         for (int i = 0; i < NUM_INTT; i++) begin
            if (!found && credit_nz[i] && (i == ((ptr_int + k) % NUM_INTT))) begin
               found = 1'b1;
               grant = ID_W'(i);
            end
         end
      end
   end

   assign wr_en        = hold_valid && !ROB_full && any_credit && !rst;
   assign cmd_ready    = !rst && (!hold_valid || wr_en);
   assign accept       = cmd_valid && cmd_ready;
   assign accept_valid = accept && (cmd_opcode != `INVALIDOP);

   always_comb begin
      state_d       = state_q;
      hold_gate_d   = hold_gate_q;
      hold_opcode_d = hold_opcode_q;
      hold_init_d   = hold_init_q;
      hold_subs_d   = hold_subs_q;
      rr_ptr_d      = rr_ptr_q;
      credit_err_d  = credit_err_q;
      credit_d      = credit_q;

      if (accept_valid) begin
         state_d       = S_HELD;
         hold_gate_d   = cmd_gate;
         hold_opcode_d = cmd_opcode;
         hold_init_d   = cmd_init_value;
         hold_subs_d   = cmd_subs_factor;
      end else if (wr_en) begin
         state_d = S_EMPTY;
      end

      if (wr_en) begin
         if (grant == ID_W'(NUM_INTT - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant + ID_W'(1);
         end
      end

      // A return to a full counter is a protocol error; the counter saturates.
      for (int i = 0; i < NUM_INTT; i++) begin
         if (iNTT_done[i] && (credit_q[i] == CREDIT_MAX)) begin
            credit_err_d = 1'b1;
         end else if (iNTT_done[i] && !(wr_en && (grant == ID_W'(i)))) begin
            credit_d[i] = credit_q[i] + CREDIT_WIDTH'(1);
         end else if (!iNTT_done[i] && wr_en && (grant == ID_W'(i))) begin
            credit_d[i] = credit_q[i] - CREDIT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_EMPTY;
         hold_gate_q   <= '0;
         hold_opcode_q <= `INVALIDOP;
         hold_init_q   <= '0;
         hold_subs_q   <= '0;
         rr_ptr_q      <= '0;
         credit_err_q  <= 1'b0;
         for (int i = 0; i < NUM_INTT; i++) begin
            credit_q[i] <= CREDIT_MAX;
         end
      end else begin
         state_q       <= state_d;
         hold_gate_q   <= hold_gate_d;
         hold_opcode_q <= hold_opcode_d;
         hold_init_q   <= hold_init_d;
         hold_subs_q   <= hold_subs_d;
         rr_ptr_q      <= rr_ptr_d;
         credit_err_q  <= credit_err_d;
         credit_q      <= credit_d;
      end
   end

   assign gate_out        = hold_gate_q;
   assign opcode_out      = hold_opcode_q;
   assign init_value_out  = hold_init_q;
   assign subs_factor_out = hold_subs_q;
   assign iNTT_id_out     = grant;
   assign busy            = hold_valid || !ROB_empty;
   assign credit_err      = credit_err_q;

endmodule

// File: tb/tb_rob_dispatch.sv
// Scoreboard bench for rob_dispatch: accepted commands are queued and compared
// against each ROB write; a small credit/round-robin model predicts iNTT ids.
`timescale 1ns/1ps
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef LWE_BIT_WIDTH
`define LWE_BIT_WIDTH 16
`endif
`ifndef INTT_ID_WIDTH
`define INTT_ID_WIDTH 2
`endif
`ifndef INVALIDOP
`define INVALIDOP 4'd0
`endif
`ifndef BOOTSTRAP
`define BOOTSTRAP 4'd1
`endif
`ifndef RLWESUBS
`define RLWESUBS 4'd2
`endif
`ifndef OR
`define OR   3'd0
`define AND  3'd1
`define NOR  3'd2
`define NAND 3'd3
`define XOR  3'd4
`define XNOR 3'd5
`endif

module tb_rob_dispatch;

   localparam int NUM  = 2;
   localparam int MAXC = 2;

   logic                        clk;
   logic                        rst;
   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [`OPCODE_WIDTH-1:0]    cmd_opcode;
   logic [2:0]                  cmd_gate;
   logic [`LWE_BIT_WIDTH-1:0]   cmd_init_value;
   logic [3:0]                  cmd_subs_factor;
   logic                        ROB_full;
   logic                        ROB_empty;
   logic                        wr_en;
   logic [2:0]                  gate_out;
   logic [`OPCODE_WIDTH-1:0]    opcode_out;
   logic [`INTT_ID_WIDTH-1:0]   iNTT_id_out;
   logic [`LWE_BIT_WIDTH-1:0]   init_value_out;
   logic [3:0]                  subs_factor_out;
   logic [NUM-1:0]              iNTT_done;
   logic                        busy;
   logic                        credit_err;

   rob_dispatch #(.NUM_INTT(NUM), .INTT_CREDITS(MAXC)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_gate(cmd_gate),
      .cmd_init_value(cmd_init_value), .cmd_subs_factor(cmd_subs_factor),
      .ROB_full(ROB_full), .ROB_empty(ROB_empty),
      .wr_en(wr_en), .gate_out(gate_out), .opcode_out(opcode_out),
      .iNTT_id_out(iNTT_id_out), .init_value_out(init_value_out),
      .subs_factor_out(subs_factor_out), .iNTT_done(iNTT_done),
      .busy(busy), .credit_err(credit_err)
   );

   typedef struct packed {
      logic [`OPCODE_WIDTH-1:0]  op;
      logic [2:0]                gate;
      logic [`LWE_BIT_WIDTH-1:0] init;
      logic [3:0]                subs;
   } sb_entry_t;

   sb_entry_t sb[$];
   int        id_log[$];
   int        cyc_log[$];
   int        cyc = 0;
   int        n_checks = 0;
   int        n_errors = 0;
   int        m_credit[NUM];
   int        m_rr = 0;
   logic      m_err = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_grant();
      int e;
      int u;
      e = -1;
      for (int k = 0; k < NUM; k++) begin
         u = (m_rr + k) % NUM;
         if (e < 0 && m_credit[u] > 0) e = u;
      end
      return e;
   endfunction

   always @(negedge clk) begin : mon
      int        eid;
      sb_entry_t e;
      if (rst) begin
         for (int i = 0; i < NUM; i++) m_credit[i] = MAXC;
         m_rr  = 0;
         m_err = 1'b0;
         sb.delete();
      end else begin
         check("credit_err_model", credit_err, m_err);
         eid = -1;
         if (wr_en) begin
            eid = exp_grant();
            check("grant_id", iNTT_id_out, eid);
            if (sb.size() == 0) begin
               check("unexpected_wr", wr_en, 0);
            end else begin
               e = sb.pop_front();
               check("opcode_out", opcode_out, e.op);
               check("gate_out", gate_out, e.gate);
               check("init_value_out", init_value_out, e.init);
               check("subs_factor_out", subs_factor_out, e.subs);
            end
            id_log.push_back(int'(iNTT_id_out));
            cyc_log.push_back(cyc);
         end
         if (cmd_valid && cmd_ready && cmd_opcode != `INVALIDOP)
            sb.push_back({cmd_opcode, cmd_gate, cmd_init_value, cmd_subs_factor});
         for (int i = 0; i < NUM; i++) begin
            if (iNTT_done[i] && m_credit[i] == MAXC) m_err = 1'b1;
            else if (iNTT_done[i] && wr_en && eid == i) m_credit[i] = m_credit[i];
            else if (iNTT_done[i]) m_credit[i] = m_credit[i] + 1;
            else if (wr_en && eid == i) m_credit[i] = m_credit[i] - 1;
         end
         if (wr_en && eid >= 0) m_rr = (eid + 1) % NUM;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [2:0] g,
                       input logic [15:0] iv, input logic [3:0] sf);
      int n;
      bit got;
      n = 0;
      got = 0;
      cmd_valid = 1'b1;
      cmd_opcode = op;
      cmd_gate = g;
      cmd_init_value = iv;
      cmd_subs_factor = sf;
      while (!got) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1;
         end else if (++n > 50) begin
            check("send_ready_timeout", cmd_ready, 1);
            got = 1;
         end
         step();
      end
   endtask

   task automatic pulse_done(input logic [NUM-1:0] d);
      iNTT_done = d;
      step();
      iNTT_done = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_opcode = `INVALIDOP;
      cmd_gate = '0;
      cmd_init_value = '0;
      cmd_subs_factor = '0;
      ROB_full = 1'b0;
      ROB_empty = 1'b1;
      iNTT_done = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_wr_en", wr_en, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_opcode", opcode_out, `INVALIDOP);
      check("rst_id", iNTT_id_out, 0);
      check("rst_busy_idle", busy, 0);
      check("rst_credit_err", credit_err, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", cmd_ready, 1);
      step();

      // back-to-back: four issues 0,1,0,1 then credit stall
      ROB_empty = 1'b0;
      id_log.delete(); cyc_log.delete();
      send(`BOOTSTRAP, `OR,   16'h0011, 4'd1);
      send(`BOOTSTRAP, `AND,  16'h0022, 4'd2);
      send(`RLWESUBS,  `NOR,  16'h0033, 4'd3);
      send(`BOOTSTRAP, `XOR,  16'h0044, 4'd4);
      send(`RLWESUBS,  `XNOR, 16'h0055, 4'd5);
      cmd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_wr_en", wr_en, 0);
         check("stall_ready", cmd_ready, 0);
         check("stall_busy", busy, 1);
         check("stall_subs_stable", subs_factor_out, 5);
         step();
      end
      iNTT_done = 2'b10;
      @(negedge clk);
      check("done_cycle_wr_en", wr_en, 0);
      step();
      iNTT_done = '0;
      @(negedge clk);
      check("resume_wr_en", wr_en, 1);
      check("resume_id", iNTT_id_out, 1);
      step();
      check("b2b_count", id_log.size(), 5);
      if (id_log.size() >= 5) begin
         check("b2b_id0", id_log[0], 0);
         check("b2b_id1", id_log[1], 1);
         check("b2b_id2", id_log[2], 0);
         check("b2b_id3", id_log[3], 1);
         check("b2b_id4", id_log[4], 1);
         check("b2b_consecutive", cyc_log[3] - cyc_log[0], 3);
      end
      pulse_done(2'b11);
      pulse_done(2'b11);

      // ROB backpressure with a held command
      ROB_full = 1'b1;
      send(`BOOTSTRAP, `NAND, 16'h1234, 4'd3);
      cmd_valid = 1'b1;
      cmd_opcode = `RLWESUBS;
      cmd_gate = `XOR;
      cmd_init_value = 16'hBEEF;
      cmd_subs_factor = 4'd7;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_wr_en", wr_en, 0);
         check("bp_ready", cmd_ready, 0);
         check("bp_opcode", opcode_out, `BOOTSTRAP);
         check("bp_gate", gate_out, `NAND);
         check("bp_init", init_value_out, 16'h1234);
         check("bp_subs", subs_factor_out, 3);
         check("bp_id", iNTT_id_out, 0);
         step();
      end
      ROB_full = 1'b0;
      @(negedge clk);
      check("bp_release_wr_en", wr_en, 1);
      check("bp_release_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_next_wr_en", wr_en, 1);
      check("bp_next_id", iNTT_id_out, 1);
      step();
      pulse_done(2'b11);

      // invalid opcode sandwiched between two RLWESUBS
      id_log.delete(); cyc_log.delete();
      send(`RLWESUBS,  `AND, 16'h0005, 4'd5);
      send(`INVALIDOP, `OR,  16'hFFFF, 4'd15);
      send(`RLWESUBS,  `OR,  16'h0009, 4'd9);
      cmd_valid = 1'b0;
      repeat (4) step();
      check("inv_count", id_log.size(), 2);
      if (id_log.size() >= 2) begin
         check("inv_id0", id_log[0], 0);
         check("inv_id1", id_log[1], 1);
      end

      // done[0] coincides with a grant to unit 0 at credit 1
      id_log.delete(); cyc_log.delete();
      send(`BOOTSTRAP, `OR, 16'h0042, 4'd1);
      cmd_valid = 1'b0;
      iNTT_done = 2'b01;
      @(negedge clk);
      check("coinc_wr_en", wr_en, 1);
      check("coinc_id", iNTT_id_out, 0);
      step();
      iNTT_done = '0;
      send(`BOOTSTRAP, `AND,  16'h0101, 4'd6);
      send(`RLWESUBS,  `NAND, 16'h0202, 4'd7);
      send(`BOOTSTRAP, `XNOR, 16'h0303, 4'd8);
      cmd_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("coinc_stall_wr_en", wr_en, 0);
         step();
      end
      check("coinc_count", id_log.size(), 3);
      if (id_log.size() >= 3) begin
         check("coinc_seq0", id_log[0], 0);
         check("coinc_seq1", id_log[1], 1);
         check("coinc_seq2", id_log[2], 0);
      end
      pulse_done(2'b11);
      @(negedge clk);
      check("coinc_resume_wr_en", wr_en, 1);
      check("coinc_resume_id", iNTT_id_out, 1);
      step();
      pulse_done(2'b10);
      pulse_done(2'b11);
      check("no_err_at_full", credit_err, 0);

      // done[1] at full credit: sticky error
      pulse_done(2'b10);
      check("credit_err_set", credit_err, 1);
      repeat (3) step();
      check("credit_err_sticky", credit_err, 1);

      // reset mid-hold, then busy behaviour
      ROB_full = 1'b1;
      send(`RLWESUBS, `XOR, 16'h7777, 4'd11);
      cmd_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_wr_en", wr_en, 0);
      check("mid_rst_ready", cmd_ready, 0);
      check("mid_rst_opcode", opcode_out, `INVALIDOP);
      check("mid_rst_gate", gate_out, 0);
      check("mid_rst_init", init_value_out, 0);
      check("mid_rst_subs", subs_factor_out, 0);
      check("mid_rst_credit_err", credit_err, 0);
      check("mid_rst_busy", busy, 1);
      ROB_full = 1'b0;
      id_log.delete(); cyc_log.delete();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rel_ready", cmd_ready, 1);
      check("busy_rob_nonempty", busy, 1);
      step();
      repeat (3) step();
      check("dropped_no_wr", id_log.size(), 0);
      ROB_empty = 1'b1;
      @(negedge clk);
      check("busy_idle", busy, 0);
      step();
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
